dm_access_ctrl: RTL and testbench
=================================

DM_ACCESS_CTRL -- requirements
Module: dm_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum REQ-state cycles waiting for mem_ack before abort (legal range 2..255).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 DM_en  input  1  SHALL be the data-memory access request from the decoder (load, store, jalr).
REQ-005 DM_write  input  1  SHALL mean store (1) or load (0), qualified by DM_en.
REQ-006 addr  input  32  SHALL be the ALU-computed byte address.
REQ-007 wdata  input  32  SHALL be the store data.
REQ-008 mem_req  output  1  SHALL be the registered memory request.
REQ-009 mem_we  output  1  SHALL be the registered write enable.
REQ-010 mem_addr  output  32  SHALL be the latched address.
REQ-011 mem_wdata  output  32  SHALL be the latched store data.
REQ-012 mem_ack  input  1  SHALL be the memory completion strobe.
REQ-013 mem_rdata  input  32  SHALL be the read data, valid with mem_ack.
REQ-014 rdata  output  32  SHALL be the captured load data for writeback (DMtoReg = DM).
REQ-015 stall  output  1  SHALL freeze the pipeline while an access is outstanding.
REQ-016 timeout  output  1  SHALL be a one-cycle pulse flagging an aborted access.

Function
REQ-017 The FSM SHALL have states IDLE, REQ and DONE, encoded in 2 bits; the unused encoding SHALL return to IDLE.
REQ-018 IDLE with DM_en=1: the block SHALL latch addr, wdata and DM_write into mem_addr, mem_wdata and mem_we, clear the wait counter, and move to REQ.
REQ-019 IDLE with DM_en=0: the block SHALL remain in IDLE, with mem_req=0 and all latches held.
REQ-020 stall SHALL be combinational: 1 when (IDLE and DM_en) or REQ, otherwise 0.
REQ-021 mem_req SHALL be 1 exactly while in REQ; mem_we, mem_addr and mem_wdata SHALL stay stable throughout REQ.
REQ-022 REQ with mem_ack=1: the block SHALL capture mem_rdata into rdata when mem_we=0, and leave rdata unchanged on a store; it SHALL then move to DONE.
REQ-023 REQ with mem_ack=0: the 8-bit wait counter SHALL increment each cycle.
REQ-024 When the counter equals TIMEOUT-1 with mem_ack=0, the block SHALL move to DONE, set rdata to 0 on a load, and pulse timeout for the DONE cycle.
REQ-025 When mem_ack and the timeout condition coincide, ack SHALL win and timeout SHALL stay 0.
REQ-026 DONE SHALL last exactly one cycle, with stall=0, and SHALL then return to IDLE unconditionally.
REQ-027 DM_en in DONE SHALL be ignored, because it belongs to the instruction already serviced.
REQ-028 mem_ack outside REQ SHALL be ignored, with no state, rdata or timeout change.
REQ-029 Minimum latency: DM_en in IDLE at cycle N, ack at N+1, gives DONE at N+2; stall SHALL be high for cycles N and N+1 only.
REQ-030 Back-to-back accesses SHALL be separated by at least one IDLE cycle after DONE.
REQ-031 rdata SHALL hold its value until the next load completion or timeout.

Reset
REQ-032 rst=1 SHALL force IDLE, counter=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0 and timeout=0 on the next edge.
REQ-033 rst=1 SHALL override all other inputs, including mid-REQ and when coincident with mem_ack.
REQ-034 stall SHALL evaluate to DM_en during reset cycles, because it is combinational in IDLE.

Verification
REQ-035 Load, zero wait: DM_en=1, DM_write=0, addr=0x100, ack next cycle with mem_rdata=0xDEADBEEF -> mem_req high 1 cycle, rdata=0xDEADBEEF in DONE, stall high 2 cycles.
REQ-036 Store, 3-wait: DM_write=1, addr=0x200, wdata=0x12345678, ack on 4th REQ cycle -> mem_we=1 and address/data stable 4 cycles, rdata unchanged.
REQ-037 Timeout: no ack, TIMEOUT=16 -> 16 REQ cycles, then DONE with timeout=1 for 1 cycle, rdata=0.
REQ-038 Ack on the final cycle: ack when counter=15 -> normal completion, timeout=0.
REQ-039 Reset mid-REQ: rst at the 2nd REQ cycle, with ack in the same cycle -> next cycle IDLE, all outputs 0, rdata not updated.
REQ-040 Spurious ack and DONE-cycle DM_en: ack in IDLE and DM_en held high through DONE -> no state change; the next access starts only from IDLE.

Source files
------------

// File: rtl/dm_access_ctrl.sv
// -----------------------------------------------------------------------------
// dm_access_ctrl
//
// Sequences one data-memory access (load, store or jalr) at a time between the
// pipeline and a memory port that may answer after a variable delay. It latches
// the request, holds it on the memory port until mem_ack arrives, captures load
// data for writeback, and gives up after TIMEOUT request cycles with no answer.
//
// Handshake: mem_req is held high for every cycle spent in REQ, and mem_we,
// mem_addr and mem_wdata do not change while it is high. The access completes
// on the first rising edge where mem_req=1 and mem_ack=1. mem_ack seen with
// mem_req=0 has no effect. On the pipeline side, a request is DM_en=1 seen in
// IDLE, and stall=1 tells the pipeline to hold that instruction until the
// access has finished.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous, active-high reset
//   DM_en      in   1   access request from the decoder
//   DM_write   in   1   1 = store, 0 = load (qualified by DM_en)
//   addr       in  32   byte address from the ALU
//   wdata      in  32   store data
//   mem_req    out  1   memory request, high while in REQ
//   mem_we     out  1   latched write enable
//   mem_addr   out 32   latched address
//   mem_wdata  out 32   latched store data
//   mem_ack    in   1   memory completion strobe
//   mem_rdata  in  32   read data, valid with mem_ack
//   rdata      out 32   captured load data for writeback
//   stall      out  1   pipeline freeze while an access is outstanding
//   timeout    out  1   one-cycle pulse, in DONE, for an aborted access
//   dbg_state  out  2   current FSM state (0 IDLE, 1 REQ, 2 DONE)
// -----------------------------------------------------------------------------
module dm_access_ctrl #(
   parameter int unsigned TIMEOUT = 16   // REQ cycles before abort, 2..255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        DM_en,
   input  logic        DM_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        timeout,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // The counter holds the number of REQ cycles already spent, so the wait
   // has run out when it reaches TIMEOUT-1 in the current REQ cycle.
   localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_cnt;
   logic        r_mem_req;
   logic        r_mem_we;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic [31:0] r_rdata;
   logic        r_timeout;

   logic        w_start;    // new access accepted this cycle
   logic        w_ack;      // memory answered this cycle
   logic        w_expire;   // last allowed REQ cycle passed with no answer

   // Next-state and control decode
   always_comb begin
      w_next   = r_state;
      w_start  = 1'b0;
      w_ack    = 1'b0;
      w_expire = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (DM_en) begin
               w_start = 1'b1;
               w_next  = ST_REQ;
            end
         end
         ST_REQ: begin
            // If the answer arrives in the last allowed cycle, the answer is
            // used and no timeout is flagged.
            if (mem_ack) begin
               w_ack  = 1'b1;
               w_next = ST_DONE;
            end else if (r_cnt == LP_CNT_LAST) begin
               w_expire = 1'b1;
               w_next   = ST_DONE;
            end
         end
         // DM_en seen here belongs to the instruction just serviced.
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 8'd0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= 32'd0;
         r_mem_wdata <= 32'd0;
         r_rdata     <= 32'd0;
         r_timeout   <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_mem_req <= (w_next == ST_REQ);
         r_timeout <= w_expire;

         if (w_start) begin
            r_mem_we    <= DM_write;
            r_mem_addr  <= addr;
            r_mem_wdata <= wdata;
            r_cnt       <= 8'd0;
         end

         if (r_state == ST_REQ && !mem_ack) begin
            r_cnt <= r_cnt + 8'd1;
         end

         // Stores leave the previous load result in place.
         if (w_ack && !r_mem_we) begin
            r_rdata <= mem_rdata;
         end else if (w_expire && !r_mem_we) begin
            r_rdata <= 32'd0;
         end
      end
   end

   // Combinational so the pipeline freezes in the same cycle the request is
   // seen; this also holds during reset while the state is IDLE.
   assign stall = ((r_state == ST_IDLE) && DM_en) || (r_state == ST_REQ);

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign rdata     = r_rdata;
   assign timeout   = r_timeout;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dm_access_ctrl
//
// Directed bench for dm_access_ctrl with TIMEOUT=16. Inputs change 1 ns after
// each rising edge. Outputs are sampled 1 ns after that. Expected load results
// are queued when a load is issued and popped when its DONE cycle is checked.
// -----------------------------------------------------------------------------
module tb_dm_access_ctrl;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic        DM_en;
   logic        DM_write;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] rdata;
   logic        stall;
   logic        timeout;
   logic [1:0]  dbg_state;

   always #5 clk = ~clk;

   dm_access_ctrl #(.TIMEOUT(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .DM_en     (DM_en),
      .DM_write  (DM_write),
      .addr      (addr),
      .wdata     (wdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .rdata     (rdata),
      .stall     (stall),
      .timeout   (timeout),
      .dbg_state (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic [31:0] exp_q[$];

   task automatic check_val(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a new access in IDLE and advance to the first REQ cycle.
   task automatic issue(input logic we, input logic [31:0] a,
                        input logic [31:0] d, input string tag);
      DM_en    = 1'b1;
      DM_write = we;
      addr     = a;
      wdata    = d;
      mem_ack  = 1'b0;
      #1;
      check_val({tag, "_issue_stall"}, 32'(stall), 32'd1);
      check_val({tag, "_issue_state"}, 32'(dbg_state), 32'(S_IDLE));
      step();
   endtask

   // Check a DONE cycle; loads pop their expected result from the queue.
   task automatic check_done(input string tag, input logic exp_to,
                             input logic is_load, input logic [31:0] keep);
      logic [31:0] exp_rd;
      #1;
      exp_rd = keep;
      if (is_load) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_queue: got empty, want one entry", tag);
         end else begin
            exp_rd = exp_q.pop_front();
         end
      end
      check_val({tag, "_done_state"},   32'(dbg_state), 32'(S_DONE));
      check_val({tag, "_done_stall"},   32'(stall), 32'd0);
      check_val({tag, "_done_req"},     32'(mem_req), 32'd0);
      check_val({tag, "_done_timeout"}, 32'(timeout), 32'(exp_to));
      check_val({tag, "_done_rdata"},   rdata, exp_rd);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no end of run, want end before 100000 ns");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      rst       = 1'b1;
      DM_en     = 1'b0;
      DM_write  = 1'b0;
      addr      = 32'd0;
      wdata     = 32'd0;
      mem_ack   = 1'b0;
      mem_rdata = 32'd0;
      step();
      step();

      // Reset state
      check_val("rst_state",   32'(dbg_state), 32'(S_IDLE));
      check_val("rst_req",     32'(mem_req), 32'd0);
      check_val("rst_we",      32'(mem_we), 32'd0);
      check_val("rst_addr",    mem_addr, 32'd0);
      check_val("rst_wdata",   mem_wdata, 32'd0);
      check_val("rst_rdata",   rdata, 32'd0);
      check_val("rst_timeout", 32'(timeout), 32'd0);
      check_val("rst_stall0",  32'(stall), 32'd0);
      // stall follows DM_en in IDLE even while reset is held
      DM_en = 1'b1;
      addr  = 32'h0000_0F00;
      #1;
      check_val("rst_stall1", 32'(stall), 32'd1);
      step();
      check_val("rst_hold_state", 32'(dbg_state), 32'(S_IDLE));
      check_val("rst_hold_addr",  mem_addr, 32'd0);
      rst   = 1'b0;
      DM_en = 1'b0;
      step();

      // Load, zero wait
      exp_q.push_back(32'hDEAD_BEEF);
      issue(1'b0, 32'h0000_0100, 32'hAAAA_5555, "ld0");
      DM_en     = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      #1;
      check_val("ld0_req",   32'(mem_req), 32'd1);
      check_val("ld0_stall", 32'(stall), 32'd1);
      check_val("ld0_we",    32'(mem_we), 32'd0);
      check_val("ld0_addr",  mem_addr, 32'h0000_0100);
      step();
      mem_ack = 1'b0;
      check_done("ld0", 1'b0, 1'b1, 32'd0);
      step();
      #1;
      check_val("ld0_idle_state", 32'(dbg_state), 32'(S_IDLE));
      check_val("ld0_idle_stall", 32'(stall), 32'd0);
      check_val("ld0_hold_rdata", rdata, 32'hDEAD_BEEF);

      // Store, ack on the 4th REQ cycle
      issue(1'b1, 32'h0000_0200, 32'h1234_5678, "st3");
      for (int i = 0; i < 4; i++) begin
         DM_en     = 1'b0;
         mem_ack   = (i == 3);
         mem_rdata = 32'hBAD0_BAD0;
         #1;
         check_val("st3_req",   32'(mem_req), 32'd1);
         check_val("st3_stall", 32'(stall), 32'd1);
         check_val("st3_we",    32'(mem_we), 32'd1);
         check_val("st3_addr",  mem_addr, 32'h0000_0200);
         check_val("st3_wdata", mem_wdata, 32'h1234_5678);
         step();
      end
      mem_ack = 1'b0;
      check_done("st3", 1'b0, 1'b0, 32'hDEAD_BEEF);
      step();

      // Timeout: no ack for 16 REQ cycles
      exp_q.push_back(32'd0);
      issue(1'b0, 32'h0000_0300, 32'd0, "to");
      for (int i = 0; i < 16; i++) begin
         DM_en   = 1'b0;
         mem_ack = 1'b0;
         #1;
         check_val("to_req",     32'(mem_req), 32'd1);
         check_val("to_timeout", 32'(timeout), 32'd0);
         step();
      end
      check_done("to", 1'b1, 1'b1, 32'd0);
      step();
      #1;
      check_val("to_pulse_end", 32'(timeout), 32'd0);
      check_val("to_idle",      32'(dbg_state), 32'(S_IDLE));

      // Ack on the final allowed cycle
      exp_q.push_back(32'hCAFE_F00D);
      issue(1'b0, 32'h0000_0400, 32'd0, "ack15");
      for (int i = 0; i < 16; i++) begin
         DM_en     = 1'b0;
         mem_ack   = (i == 15);
         mem_rdata = 32'hCAFE_F00D;
         #1;
         check_val("ack15_req", 32'(mem_req), 32'd1);
         step();
      end
      mem_ack = 1'b0;
      check_done("ack15", 1'b0, 1'b1, 32'd0);
      step();

      // Reset in the 2nd REQ cycle, together with ack
      issue(1'b1, 32'h0000_0500, 32'h5555_5555, "rmid");
      DM_en = 1'b0;
      #1;
      check_val("rmid_req1", 32'(dbg_state), 32'(S_REQ));
      step();
      rst       = 1'b1;
      mem_ack   = 1'b1;
      mem_rdata = 32'h1111_1111;
      #1;
      check_val("rmid_req2", 32'(dbg_state), 32'(S_REQ));
      step();
      rst     = 1'b0;
      mem_ack = 1'b0;
      #1;
      check_val("rmid_state",   32'(dbg_state), 32'(S_IDLE));
      check_val("rmid_req",     32'(mem_req), 32'd0);
      check_val("rmid_we",      32'(mem_we), 32'd0);
      check_val("rmid_addr",    mem_addr, 32'd0);
      check_val("rmid_wdata",   mem_wdata, 32'd0);
      check_val("rmid_rdata",   rdata, 32'd0);
      check_val("rmid_timeout", 32'(timeout), 32'd0);

      // Spurious ack in IDLE
      mem_ack   = 1'b1;
      mem_rdata = 32'h2222_2222;
      #1;
      check_val("sp_idle_stall", 32'(stall), 32'd0);
      step();
      mem_ack = 1'b0;
      #1;
      check_val("sp_idle_state",   32'(dbg_state), 32'(S_IDLE));
      check_val("sp_idle_rdata",   rdata, 32'd0);
      check_val("sp_idle_timeout", 32'(timeout), 32'd0);
      check_val("sp_idle_req",     32'(mem_req), 32'd0);

      // DM_en held high through DONE, plus an ack during DONE
      exp_q.push_back(32'h600D_600D);
      issue(1'b0, 32'h0000_0600, 32'd0, "hold");
      DM_en     = 1'b1;
      mem_ack   = 1'b1;
      mem_rdata = 32'h600D_600D;
      #1;
      check_val("hold_req", 32'(mem_req), 32'd1);
      step();
      DM_en     = 1'b1;
      mem_ack   = 1'b1;
      mem_rdata = 32'h3333_3333;
      check_done("hold", 1'b0, 1'b1, 32'd0);
      step();
      DM_en   = 1'b1;
      mem_ack = 1'b0;
      addr    = 32'h0000_0700;
      #1;
      check_val("hold_idle_state", 32'(dbg_state), 32'(S_IDLE));
      check_val("hold_idle_stall", 32'(stall), 32'd1);
      check_val("hold_idle_req",   32'(mem_req), 32'd0);
      check_val("hold_idle_rdata", rdata, 32'h600D_600D);
      exp_q.push_back(32'h7777_7777);
      step();
      DM_en     = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 32'h7777_7777;
      #1;
      check_val("next_req",  32'(mem_req), 32'd1);
      check_val("next_addr", mem_addr, 32'h0000_0700);
      step();
      mem_ack = 1'b0;
      check_done("next", 1'b0, 1'b1, 32'd0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
